reg_file_sb: RTL and testbench

//  Parametrised successor of the pipeline register file: NUM_RD combinational read ports,
//  one write port, optional write->read bypass, and a per-register pending-write scoreboard.

---
 rtl/reg_file_sb_pkg.sv | 15 +
 rtl/reg_file_sb_if.sv | 31 +++
 rtl/reg_file_sb_pend_ctr.sv | 53 +++++
 rtl/reg_file_sb.sv | 107 ++++++++++
 tb/tb_reg_file_sb.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_file_sb_pkg.sv
// Shared definitions for the scoreboarded register file: default widths,
// the hardwired-zero register index and packed-port slicing.
package cod_rf_pkg;

  localparam int RF_DATA_WIDTH = 32;
  localparam int RF_ADDR_WIDTH = 5;
  localparam int RF_NUM_RD     = 2;
  localparam int ZERO_REG      = 0;

  // Bit offset of port 'port' inside a packed multi-port vector of 'width'-bit fields.
  function automatic int rf_slice(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/reg_file_sb_if.sv
// Bus bundle between the pipeline (ID/WB side) and the register file.
// master drives addresses, write data and issue/flush; slave returns read data and status.
interface reg_file_sb_if
  import cod_rf_pkg::*;
#(
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int NUM_RD     = RF_NUM_RD
);
  logic [NUM_RD*ADDR_WIDTH-1:0] raddr;
  logic [NUM_RD*DATA_WIDTH-1:0] rdata;
  logic [NUM_RD-1:0]            rvalid;
  logic                         wen;
  logic [ADDR_WIDTH-1:0]        waddr;
  logic [DATA_WIDTH-1:0]        wdata;
  logic                         iss_en;
  logic [ADDR_WIDTH-1:0]        iss_addr;
  logic                         iss_ready;
  logic                         flush;
  logic                         pend_any;

  modport master (
    output raddr, wen, waddr, wdata, iss_en, iss_addr, flush,
    input  rdata, rvalid, iss_ready, pend_any
  );

  modport slave (
    input  raddr, wen, waddr, wdata, iss_en, iss_addr, flush,
    output rdata, rvalid, iss_ready, pend_any
  );
endinterface

// File: rtl/reg_file_sb_pend_ctr.sv
// Per-register pending-write counter: saturating up (issue), floored down
// (release), synchronous clear (flush) with priority over both.
module rf_pend_ctr #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  input  logic             i_dec,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_sat,
  output logic             o_nz
);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_up;
  logic             w_dn;

  // An issue at saturation and a release at zero are dropped; both together cancel.
  assign w_up = i_inc & (r_cnt != CNT_MAX);
  assign w_dn = i_dec & (r_cnt != CNT_ZERO);

  // Next-count selection: clear wins, then net up/down movement.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_clr) begin
      w_cnt_nxt = CNT_ZERO;
    end else if (w_up && !w_dn) begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end else if (w_dn && !w_up) begin
      w_cnt_nxt = r_cnt - CNT_W'(1);
    end else begin
      w_cnt_nxt = r_cnt;
    end
  end

  // Counter state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= CNT_ZERO;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

  assign o_cnt = r_cnt;
  assign o_sat = (r_cnt == CNT_MAX);
  assign o_nz  = (r_cnt != CNT_ZERO);
endmodule

// File: rtl/reg_file_sb.sv
// Register file with NUM_RD combinational read ports, one write port,
// optional same-cycle write forwarding and a pending-write scoreboard.
// x0 has no storage and no counter; it always reads 0 and is always valid.
module reg_file_sb
  import cod_rf_pkg::*;
#(
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int NUM_RD     = RF_NUM_RD,
  parameter int BYPASS     = 1,
  parameter int CNT_W      = 2
) (
  input  logic          clk,
  input  logic          rst,
  reg_file_sb_if.slave  bus
);
  localparam int                    DEPTH    = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] X0       = ADDR_WIDTH'(ZERO_REG);
  localparam logic                  BYP      = (BYPASS != 0);
  localparam logic [CNT_W-1:0]      CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);

  logic [DATA_WIDTH-1:0] r_rf [1:DEPTH-1];
  logic [CNT_W-1:0]      w_cnt [DEPTH];
  logic                  w_sat [DEPTH];
  logic                  w_nz  [DEPTH];
  logic                  w_wr;
  logic                  w_pend;

  assign w_wr     = bus.wen && (bus.waddr != X0);
  assign w_cnt[0] = CNT_ZERO;
  assign w_sat[0] = 1'b0;
  assign w_nz[0]  = 1'b0;

  // One scoreboard counter per architectural register except x0.
  for (genvar g = 1; g < DEPTH; g++) begin : g_ctr
    logic w_inc;
    logic w_dec;
    assign w_inc = bus.iss_en && (bus.iss_addr == ADDR_WIDTH'(g));
    assign w_dec = w_wr && (bus.waddr == ADDR_WIDTH'(g));
    rf_pend_ctr #(.CNT_W(CNT_W)) u_ctr (
      .clk   (clk),
      .rst   (rst),
      .i_inc (w_inc),
      .i_dec (w_dec),
      .i_clr (bus.flush),
      .o_cnt (w_cnt[g]),
      .o_sat (w_sat[g]),
      .o_nz  (w_nz[g])
    );
  end

  // Register storage; writes to x0 are dropped because x0 has no entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < DEPTH; i++) begin
        r_rf[i] <= {DATA_WIDTH{1'b0}};
      end
    end else if (w_wr) begin
      r_rf[bus.waddr] <= bus.wdata;
    end else begin
      r_rf <= r_rf;
    end
  end

  // Any register with an outstanding write.
  always_comb begin
    w_pend = 1'b0;
    for (int i = 1; i < DEPTH; i++) begin
      w_pend = w_pend | w_nz[i];
    end
  end

  assign bus.pend_any  = w_pend;
  // Ignores a same-cycle release on purpose: keeps the issue path short.
  assign bus.iss_ready = (bus.iss_addr == X0) | ~w_sat[bus.iss_addr];

  // Read ports: x0 first, then forwarded write data, then stored value.
  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_WIDTH-1:0] w_ra;
    logic                  w_hit;
    logic [DATA_WIDTH-1:0] w_rd;
    logic                  w_rv;

    assign w_ra  = bus.raddr[rf_slice(p, ADDR_WIDTH) +: ADDR_WIDTH];
    assign w_hit = BYP && bus.wen && (bus.waddr == w_ra);

    // A forwarded write completes the last outstanding reservation, so count 1 is final.
    always_comb begin
      w_rd = {DATA_WIDTH{1'b0}};
      w_rv = 1'b1;
      if (w_ra == X0) begin
        w_rd = {DATA_WIDTH{1'b0}};
        w_rv = 1'b1;
      end else if (w_hit) begin
        w_rd = bus.wdata;
        w_rv = (w_cnt[w_ra] == CNT_ZERO) | (w_cnt[w_ra] == CNT_ONE);
      end else begin
        w_rd = r_rf[w_ra];
        w_rv = (w_cnt[w_ra] == CNT_ZERO);
      end
    end

    assign bus.rdata[rf_slice(p, DATA_WIDTH) +: DATA_WIDTH] = w_rd;
    assign bus.rvalid[p] = w_rv;
  end
endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: two instances (forwarding on / off) share one stimulus
// stream and are compared against an array-based model of the register file
// and its per-register outstanding-write counts.
module tb_reg_file_sb;
  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int NR   = 2;
  localparam int MAXC = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass  = 0;
  int   n_total = 0;

  logic [31:0] m_rf  [32];
  int          m_cnt [32];

  reg_file_sb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR)) if_b ();
  reg_file_sb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR)) if_n ();

  reg_file_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR), .BYPASS(1), .CNT_W(2))
    dut_b (.clk(clk), .rst(rst), .bus(if_b));
  reg_file_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR), .BYPASS(0), .CNT_W(2))
    dut_n (.clk(clk), .rst(rst), .bus(if_n));

  assign if_n.raddr    = if_b.raddr;
  assign if_n.wen      = if_b.wen;
  assign if_n.waddr    = if_b.waddr;
  assign if_n.wdata    = if_b.wdata;
  assign if_n.iss_en   = if_b.iss_en;
  assign if_n.iss_addr = if_b.iss_addr;
  assign if_n.flush    = if_b.flush;

  always #5 clk = ~clk;

  function automatic logic [31:0] mdl_rdata(input bit byp, input int ra);
    if (ra == 0) return 32'h0;
    if (byp && if_b.wen && int'(if_b.waddr) == ra) return if_b.wdata;
    return m_rf[ra];
  endfunction

  function automatic bit mdl_rvalid(input bit byp, input int ra);
    if (ra == 0) return 1'b1;
    if (m_cnt[ra] == 0) return 1'b1;
    return byp && if_b.wen && int'(if_b.waddr) == ra && m_cnt[ra] == 1;
  endfunction

  task automatic mdl_reset();
    for (int i = 0; i < 32; i++) begin
      m_rf[i]  = 32'h0;
      m_cnt[i] = 0;
    end
  endtask

  // Advance the model by the edge about to happen, then move to the next falling edge.
  task automatic tick();
    int nc [32];
    int wa;
    int ia;
    nc = m_cnt;
    wa = int'(if_b.waddr);
    ia = int'(if_b.iss_addr);
    if (if_b.wen && wa != 0) m_rf[wa] = if_b.wdata;
    if (if_b.flush) begin
      for (int i = 0; i < 32; i++) nc[i] = 0;
    end else begin
      if (if_b.iss_en && ia != 0 && m_cnt[ia] != MAXC) nc[ia] = nc[ia] + 1;
      if (if_b.wen && wa != 0 && m_cnt[wa] != 0) nc[wa] = nc[wa] - 1;
    end
    m_cnt = nc;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    if_b.wen    = 1'b0;
    if_b.iss_en = 1'b0;
    if_b.flush  = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    if_b.waddr = 5'd0; if_b.wdata = 32'h0; if_b.iss_addr = 5'd9;
    if_b.raddr = {5'd17, 5'd4};
    rst = 1'b1;
    mdl_reset();
    @(negedge clk);
    #1;
    n_total++; if (if_b.pend_any !== 1'b0) $display("FAIL reset_pend_any got=%0b exp=0", if_b.pend_any); else n_pass++;
    n_total++; if (if_b.iss_ready !== 1'b1) $display("FAIL reset_iss_ready got=%0b exp=1", if_b.iss_ready); else n_pass++;
    n_total++; if (if_b.rvalid !== 2'b11 || if_n.rvalid !== 2'b11) $display("FAIL reset_rvalid got=%b/%b exp=11", if_b.rvalid, if_n.rvalid); else n_pass++;
    n_total++; if (if_b.rdata !== 64'h0 || if_n.rdata !== 64'h0) $display("FAIL reset_rdata got=%h/%h exp=0", if_b.rdata, if_n.rdata); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    idle();
    if_b.wen = 1'b1; if_b.waddr = 5'd5; if_b.wdata = 32'hDEADBEEF;
    tick();
    idle();
    if_b.raddr = {5'd0, 5'd5};
    #1;
    n_total++; if (if_b.rdata[31:0] !== 32'hDEADBEEF || if_n.rdata[31:0] !== 32'hDEADBEEF) $display("FAIL wr_rdata0 got=%h/%h exp=deadbeef", if_b.rdata[31:0], if_n.rdata[31:0]); else n_pass++;
    n_total++; if (if_b.rvalid[0] !== 1'b1) $display("FAIL wr_rvalid0 got=%0b exp=1", if_b.rvalid[0]); else n_pass++;
    n_total++; if (if_b.rdata[63:32] !== 32'h0 || if_b.rvalid[1] !== 1'b1) $display("FAIL wr_rdata1_x0 got=%h/%0b exp=0/1", if_b.rdata[63:32], if_b.rvalid[1]); else n_pass++;
  endtask

  task automatic test_x0();
    if_b.wen = 1'b1; if_b.waddr = 5'd0; if_b.wdata = 32'hFFFFFFFF;
    if_b.iss_en = 1'b1; if_b.iss_addr = 5'd0;
    if_b.raddr = {5'd0, 5'd0};
    #1;
    n_total++; if (if_b.rdata !== 64'h0) $display("FAIL x0_bypass_rdata got=%h exp=0", if_b.rdata); else n_pass++;
    n_total++; if (if_b.iss_ready !== 1'b1) $display("FAIL x0_iss_ready got=%0b exp=1", if_b.iss_ready); else n_pass++;
    tick();
    idle();
    #1;
    n_total++; if (if_b.rdata !== 64'h0 || if_n.rdata !== 64'h0) $display("FAIL x0_rdata got=%h/%h exp=0", if_b.rdata, if_n.rdata); else n_pass++;
    n_total++; if (if_b.pend_any !== 1'b0) $display("FAIL x0_pend_any got=%0b exp=0", if_b.pend_any); else n_pass++;
  endtask

  task automatic test_saturate();
    logic [31:0] last;
    for (int k = 0; k < 3; k++) begin
      idle(); if_b.iss_en = 1'b1; if_b.iss_addr = 5'd7;
      #1;
      n_total++; if (if_b.iss_ready !== 1'b1) $display("FAIL sat_ready_%0d got=%0b exp=1", k, if_b.iss_ready); else n_pass++;
      tick();
    end
    idle(); if_b.iss_en = 1'b1; if_b.iss_addr = 5'd7;
    #1;
    n_total++; if (if_b.iss_ready !== 1'b0) $display("FAIL sat_ready_full got=%0b exp=0", if_b.iss_ready); else n_pass++;
    tick();
    idle(); if_b.raddr = {5'd0, 5'd7};
    #1;
    n_total++; if (if_b.rvalid[0] !== 1'b0 || if_b.pend_any !== 1'b1) $display("FAIL sat_pending got=%0b/%0b exp=0/1", if_b.rvalid[0], if_b.pend_any); else n_pass++;
    last = 32'h0;
    for (int k = 0; k < 3; k++) begin
      last = $urandom;
      if_b.wen = 1'b1; if_b.waddr = 5'd7; if_b.wdata = last;
      #1;
      n_total++; if (if_b.rvalid[0] !== (k == 2) || if_n.rvalid[0] !== 1'b0) $display("FAIL sat_release_rvalid_%0d got=%0b/%0b exp=%0b/0", k, if_b.rvalid[0], if_n.rvalid[0], (k == 2)); else n_pass++;
      tick();
    end
    idle();
    #1;
    n_total++; if (if_b.rvalid[0] !== 1'b1 || if_n.rvalid[0] !== 1'b1) $display("FAIL sat_drained_rvalid got=%0b/%0b exp=1", if_b.rvalid[0], if_n.rvalid[0]); else n_pass++;
    n_total++; if (if_b.rdata[31:0] !== last) $display("FAIL sat_drained_rdata got=%h exp=%h", if_b.rdata[31:0], last); else n_pass++;
  endtask

  task automatic test_bypass();
    idle(); if_b.wen = 1'b1; if_b.waddr = 5'd3; if_b.wdata = 32'hA5A50003;
    tick();
    idle(); if_b.iss_en = 1'b1; if_b.iss_addr = 5'd3;
    tick();
    idle(); if_b.wen = 1'b1; if_b.waddr = 5'd3; if_b.wdata = 32'h00001234;
    if_b.raddr = {5'd5, 5'd3};
    #1;
    n_total++; if (if_b.rdata[31:0] !== 32'h00001234 || if_b.rvalid[0] !== 1'b1) $display("FAIL byp_on got=%h/%0b exp=00001234/1", if_b.rdata[31:0], if_b.rvalid[0]); else n_pass++;
    n_total++; if (if_n.rdata[31:0] !== 32'hA5A50003 || if_n.rvalid[0] !== 1'b0) $display("FAIL byp_off got=%h/%0b exp=a5a50003/0", if_n.rdata[31:0], if_n.rvalid[0]); else n_pass++;
    tick();
    idle();
    #1;
    n_total++; if (if_n.rdata[31:0] !== 32'h00001234 || if_n.rvalid[0] !== 1'b1) $display("FAIL byp_after got=%h/%0b exp=00001234/1", if_n.rdata[31:0], if_n.rvalid[0]); else n_pass++;
  endtask

  task automatic test_iss_rel_same();
    idle(); if_b.iss_en = 1'b1; if_b.iss_addr = 5'd9;
    tick();
    if_b.wen = 1'b1; if_b.waddr = 5'd9; if_b.wdata = 32'h99990009;
    tick();
    idle(); if_b.raddr = {5'd0, 5'd9};
    #1;
    n_total++; if (if_b.rvalid[0] !== 1'b0 || if_b.pend_any !== 1'b1) $display("FAIL same_cnt_kept got=%0b/%0b exp=0/1", if_b.rvalid[0], if_b.pend_any); else n_pass++;
    if_b.wen = 1'b1; if_b.waddr = 5'd9; if_b.wdata = 32'h0;
    #1;
    n_total++; if (if_b.rvalid[0] !== 1'b1) $display("FAIL same_cnt_is_one got=%0b exp=1", if_b.rvalid[0]); else n_pass++;
    idle(); if_b.flush = 1'b1; if_b.iss_en = 1'b1; if_b.iss_addr = 5'd9;
    tick();
    idle();
    #1;
    n_total++; if (if_b.rvalid[0] !== 1'b1 || if_b.pend_any !== 1'b0) $display("FAIL flush_clear got=%0b/%0b exp=1/0", if_b.rvalid[0], if_b.pend_any); else n_pass++;
    n_total++; if (if_b.rdata[31:0] !== 32'h99990009) $display("FAIL same_data got=%h exp=99990009", if_b.rdata[31:0]); else n_pass++;
  endtask

  task automatic test_random();
    int ra;
    for (int c = 0; c < 400; c++) begin
      if_b.wen      = ($urandom_range(0, 1) == 1);
      if_b.waddr    = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      if_b.wdata    = $urandom;
      if_b.iss_en   = ($urandom_range(0, 1) == 1);
      if_b.iss_addr = 5'($urandom_range(0, 7));
      if_b.flush    = ($urandom_range(0, 15) == 0);
      if_b.raddr    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      #1;
      for (int p = 0; p < NR; p++) begin
        ra = int'(if_b.raddr[p*AW +: AW]);
        n_total++;
        if (if_b.rdata[p*DW +: DW] !== mdl_rdata(1'b1, ra) || if_b.rvalid[p] !== mdl_rvalid(1'b1, ra)
            || if_n.rdata[p*DW +: DW] !== mdl_rdata(1'b0, ra) || if_n.rvalid[p] !== mdl_rvalid(1'b0, ra))
          $display("FAIL rnd_read c=%0d p=%0d x%0d got=%h/%0b %h/%0b exp=%h/%0b %h/%0b", c, p, ra,
                   if_b.rdata[p*DW +: DW], if_b.rvalid[p], if_n.rdata[p*DW +: DW], if_n.rvalid[p],
                   mdl_rdata(1'b1, ra), mdl_rvalid(1'b1, ra), mdl_rdata(1'b0, ra), mdl_rvalid(1'b0, ra));
        else n_pass++;
      end
      begin
        bit exp_pend;
        bit exp_rdy;
        exp_pend = 1'b0;
        for (int i = 1; i < 32; i++) if (m_cnt[i] != 0) exp_pend = 1'b1;
        exp_rdy = (if_b.iss_addr == 5'd0) || (m_cnt[int'(if_b.iss_addr)] != MAXC);
        n_total++;
        if (if_b.pend_any !== exp_pend || if_b.iss_ready !== exp_rdy || if_n.pend_any !== exp_pend)
          $display("FAIL rnd_status c=%0d got=%0b/%0b exp=%0b/%0b", c, if_b.pend_any, if_b.iss_ready, exp_pend, exp_rdy);
        else n_pass++;
      end
      tick();
    end
    idle();
    if_b.flush = 1'b1;
    tick();
    idle();
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    idle(); if_b.wen = 1'b1; if_b.waddr = 5'd2; if_b.wdata = 32'h22222222;
    tick();
    idle(); if_b.iss_en = 1'b1; if_b.iss_addr = 5'd2;
    tick();
    if_b.iss_addr = 5'd4;
    tick();
    idle();
    d = $urandom;
    if_b.wen = 1'b1; if_b.waddr = 5'd6; if_b.wdata = d;
    if_b.raddr = {5'd4, 5'd2};
    #1;
    n_total++; if (if_b.pend_any !== 1'b1 || if_b.rvalid !== 2'b00) $display("FAIL mid_pre got=%0b/%b exp=1/00", if_b.pend_any, if_b.rvalid); else n_pass++;
    #1;
    rst = 1'b1;
    mdl_reset();
    #1;
    n_total++; if (if_b.pend_any !== 1'b0 || if_b.rvalid !== 2'b11 || if_n.rvalid !== 2'b11) $display("FAIL mid_rst_status got=%0b/%b/%b exp=0/11/11", if_b.pend_any, if_b.rvalid, if_n.rvalid); else n_pass++;
    n_total++; if (if_b.rdata !== 64'h0 || if_n.rdata !== 64'h0) $display("FAIL mid_rst_rdata got=%h/%h exp=0", if_b.rdata, if_n.rdata); else n_pass++;
    @(posedge clk);
    @(negedge clk);
    idle();
    rst = 1'b0;
    if_b.raddr = {5'd5, 5'd6};
    #1;
    n_total++; if (if_b.rdata !== 64'h0 || if_n.rdata !== 64'h0) $display("FAIL mid_write_dropped got=%h/%h exp=0", if_b.rdata, if_n.rdata); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_x0();
    test_saturate();
    test_bypass();
    test_iss_rel_same();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
